// File: rtl/dict_search_ctrl.sv
// Sequential dictionary search: walks the name store newest-to-oldest, one
// character per synchronous read, and reports found/index with a done pulse.
module dict_search_ctrl #(
  parameter  int ENTRIES    = 2,
  parameter  int KEY_WIDTH  = 8,
  parameter  int KEY_LENGTH = 1,
  localparam int INDEX_BITS = $clog2(ENTRIES) + 1,
  localparam int CHAR_BITS  = $clog2(KEY_LENGTH) + 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_req,
  input  logic [KEY_WIDTH*KEY_LENGTH-1:0] i_key,
  input  logic [INDEX_BITS-1:0]           i_count,
  input  logic                            i_abort,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_found,
  output logic [INDEX_BITS-1:0]           o_index,
  output logic                            o_rd_en,
  output logic [INDEX_BITS-1:0]           o_rd_entry,
  output logic [CHAR_BITS-1:0]            o_rd_char,
  input  logic [KEY_WIDTH-1:0]            i_rd_data
);

  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;

  state_t                          state;
  logic [KEY_WIDTH*KEY_LENGTH-1:0] key_q;
  logic [INDEX_BITS-1:0]           cnt;
  logic [KEY_WIDTH-1:0]            cur_char;
  logic                            match, last_char;

  assign cnt = (i_count > INDEX_BITS'(ENTRIES)) ? INDEX_BITS'(ENTRIES) : i_count;

  // o_rd_entry/o_rd_char double as the search cursor; they only move on a read.
  always_comb begin
    cur_char = '0;
    for (int k = 0; k < KEY_LENGTH; k++)
      if (o_rd_char == CHAR_BITS'(k)) cur_char = key_q[k*KEY_WIDTH +: KEY_WIDTH];
  end

  assign match     = (i_rd_data == cur_char);
  assign last_char = (o_rd_char == CHAR_BITS'(KEY_LENGTH-1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      key_q      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_found    <= 1'b0;
      o_index    <= '0;
      o_rd_en    <= 1'b0;
      o_rd_entry <= '0;
      o_rd_char  <= '0;
    end else if (i_abort) begin
      state   <= IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_found <= 1'b0;
      o_index <= '0;
      o_rd_en <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_rd_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (i_req) begin
            key_q   <= i_key;
            o_found <= 1'b0;
            o_index <= '0;
            if (cnt == '0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state      <= READ;
              o_busy     <= 1'b1;
              o_rd_en    <= 1'b1;
              o_rd_entry <= cnt - INDEX_BITS'(1);
              o_rd_char  <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
        READ: state <= CMP;
        CMP: begin
          if (match && last_char) begin
            state   <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_found <= 1'b1;
            o_index <= o_rd_entry;
          end else if (match) begin
            state     <= READ;
            o_rd_en   <= 1'b1;
            o_rd_char <= o_rd_char + CHAR_BITS'(1);
          end else if (o_rd_entry != '0) begin
            // Mismatch skips the rest of this name and moves to the next older entry.
            state      <= READ;
            o_rd_en    <= 1'b1;
            o_rd_entry <= o_rd_entry - INDEX_BITS'(1);
            o_rd_char  <= '0;
          end else begin
            state   <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_found <= 1'b0;
            o_index <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dict_search_ctrl.md
# dict_search_ctrl

Sequential dictionary search controller for the Forth CPU dictionary. It accepts a lookup key through a request/busy handshake and walks the dictionary name store one character per read, from the newest entry to the oldest. It reports the result with a one-cycle done pulse plus held found/index outputs. It replaces a single-cycle all-entries comparator with one shared synchronous-RAM read port, so dictionary size is no longer bounded by comparator area.

## Interface
- ENTRIES, 2, dictionary capacity in entries
- KEY_WIDTH, 8, bits per name character
- KEY_LENGTH, 1, characters per name; all names are exactly KEY_LENGTH characters
- INDEX_BITS (localparam), $clog2(ENTRIES)+1, width of entry index and count

Ports:
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  start request; accepted only while o_busy=0
- i_key  in  KEY_WIDTH*KEY_LENGTH  key to find; char 0 in bits [KEY_WIDTH-1:0]; latched on acceptance
- i_count  in  INDEX_BITS  number of valid entries (0..ENTRIES); sampled on acceptance
- i_abort  in  1  cancel the search in progress
- o_busy  out  1  high while a search is in progress
- o_done  out  1  one-cycle pulse when the result is valid
- o_found  out  1  result: key matched an entry
- o_index  out  INDEX_BITS  matching entry number; 0 when not found
- o_rd_en  out  1  name-store read strobe
- o_rd_entry  out  INDEX_BITS  entry address of the read
- o_rd_char  out  $clog2(KEY_LENGTH)+1  character address of the read
- i_rd_data  in  KEY_WIDTH  name-store data, valid exactly one cycle after o_rd_en

## Operation
- States: IDLE, READ, CMP, DONE.
- Acceptance happens in IDLE or DONE when i_req=1 at a rising edge:
  - Latch i_key.
  - Load the counter with min(i_count, ENTRIES).
  - If the count is 0, go to DONE with o_found=0.
  - Otherwise set entry=count-1 and char=0, clear o_found/o_index, and go to READ.
- READ: drive o_rd_en=1, o_rd_entry=entry, o_rd_char=char; go to CMP.
- CMP: compare i_rd_data with latched key char[char]. Exactly one of the following applies:
  - Match and char=KEY_LENGTH-1: set o_found=1 and o_index=entry; go to DONE.
  - Match and not last char: increment char; go to READ.
  - Mismatch and entry>0: decrement entry, set char=0; go to READ. Remaining chars of the mismatching entry are skipped.
  - Mismatch and entry=0: set o_found=0 and o_index=0; go to DONE.
- DONE: o_done=1 for this cycle only. Go to IDLE, or straight to READ/DONE if a new request is accepted.
- Search order is newest first, so the highest-index match wins. This gives Forth redefinition semantics.
- o_found/o_index hold their value from DONE until the next acceptance.
- o_busy=1 in READ and CMP; 0 in IDLE and DONE.
- i_req while o_busy=1 is ignored. It is not queued.
- i_abort=1 has priority over everything except reset:
  - Next state is IDLE.
  - o_done is not pulsed.
  - o_found and o_index are cleared.
  - o_rd_en is low from the next cycle.
  - i_abort in IDLE/DONE together with i_req: the abort wins and the request is dropped.
- i_count, i_key and store contents may change during a search without effect on key/count. The store must not be written during a search; the result is undefined if it is.

## Timing
- Reset (asynchronous, any state): state=IDLE. o_busy, o_done, o_found, o_rd_en = 0; o_index, o_rd_entry, o_rd_char = 0.
- Cycle numbering: cycle 1 is the first cycle after the accepting edge.
- With N total character comparisons:
  - READ occupies odd cycles 1..2N-1; CMP occupies even cycles 2..2N.
  - o_done is high in cycle 2N+1.
- Count=0: o_done is high in cycle 1.
- Best case (hit on the newest entry): latency 2*KEY_LENGTH+1.
- Worst case: 2*ENTRIES*KEY_LENGTH+1.
- Back-to-back requests: i_req held high through DONE starts the next search with READ in the following cycle. Throughput loses no idle cycle.
- o_rd_en is never high in two consecutive cycles.
- o_rd_entry and o_rd_char hold their last value when o_rd_en=0.

## Test plan
Parameters for all scenarios: ENTRIES=4, KEY_LENGTH=2, KEY_WIDTH=8. Store contents: entry0="DU", entry1="SW", entry2="DR", entry3="DU".

- Duplicate name, newest wins: count=4, key "DU" -> hit on entry3 on the first try; o_done in cycle 5, o_found=1, o_index=3.
- Oldest entry, early-mismatch skip: count=4, key "SW" -> entry3 mismatches on char0, entry2 on char0, entry1 matches both chars. N=4, o_done in cycle 9, o_index=1.
- Miss: key "XX", count=4 -> N=4, o_done in cycle 9, o_found=0, o_index=0. Same key with count=0 -> o_done in cycle 1, o_found=0.
- Count limits: count=2, key "DR" -> miss (entry2 is excluded). Count=7 -> clamped to 4; first read has o_rd_entry=3.
- Abort: abort asserted in cycle 3 of a "SW" search -> o_busy=0 and o_rd_en=0 from cycle 4, no o_done, o_found=0. A new "DU" request then completes normally with o_index=3.
- Reset and request-while-busy: i_rst_n low during CMP -> all outputs 0 immediately. i_req pulsed while o_busy=1 -> ignored; exactly one o_done. Back-to-back requests with i_req held -> READ follows DONE directly.
